// File: rtl/vga_screen_mux.sv
// Frame-synchronous N-way VGA stream selector with black (or fade-in) frames after a switch.
// Optional fade-in during the blank phase: define SCREEN_MUX_FADE_EN.
module vga_screen_mux #(
  parameter int N_SRC        = 4,
  parameter int CNT_W        = 11,
  parameter int RGB_W        = 12,
  parameter int RST_SRC      = 0,
  parameter int BLANK_FRAMES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(N_SRC)-1:0]   sel,
  input  logic [N_SRC*CNT_W-1:0]     src_hcount,
  input  logic [N_SRC*CNT_W-1:0]     src_vcount,
  input  logic [N_SRC-1:0]           src_hsync,
  input  logic [N_SRC-1:0]           src_vsync,
  input  logic [N_SRC-1:0]           src_hblnk,
  input  logic [N_SRC-1:0]           src_vblnk,
  input  logic [N_SRC*RGB_W-1:0]     src_rgb,
  output logic [CNT_W-1:0]           out_hcount,
  output logic [CNT_W-1:0]           out_vcount,
  output logic                       out_hsync,
  output logic                       out_vsync,
  output logic                       out_hblnk,
  output logic                       out_vblnk,
  output logic [RGB_W-1:0]           out_rgb,
  output logic [$clog2(N_SRC)-1:0]   cur_src,
  output logic                       switching
);

  localparam int SEL_W = $clog2(N_SRC);
  localparam int CH_W  = RGB_W / 3;

  typedef enum logic [1:0] {SHOW, PENDING, BLANK} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] cur, cur_nxt, pend;
  logic [3:0]       blank_cnt, cnt_nxt;
  logic             fs, sel_ok;
  logic [RGB_W-1:0] rgb_sel, rgb_nxt;

  assign sel_ok = 32'(sel) < N_SRC;
  assign fs     = (src_hcount[CNT_W*int'(cur) +: CNT_W] == '0) &&
                  (src_vcount[CNT_W*int'(cur) +: CNT_W] == '0);

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    cnt_nxt   = blank_cnt;
    case (state)
      SHOW: begin
        if (pend != cur) state_nxt = PENDING;
      end
      PENDING: begin
        if (pend == cur) begin
          state_nxt = SHOW;
        end else if (fs) begin
          cur_nxt = pend;
          if (BLANK_FRAMES == 0) begin
            state_nxt = SHOW;
          end else begin
            state_nxt = BLANK;
            cnt_nxt   = 4'(BLANK_FRAMES);
          end
        end
      end
      BLANK: begin
        // The blank phase always runs to completion; pend is only re-examined at its end.
        if (fs) begin
          cnt_nxt = blank_cnt - 4'd1;
          if (cnt_nxt == 4'd0) state_nxt = (pend != cur) ? PENDING : SHOW;
        end
      end
      default: state_nxt = SHOW;
    endcase
  end

  // Output pixel follows the post-edge source and state so the switch lands exactly on fs.
  always_comb begin
    rgb_sel = src_rgb[RGB_W*int'(cur_nxt) +: RGB_W];
    rgb_nxt = rgb_sel;
    if (state_nxt == BLANK) begin
`ifdef SCREEN_MUX_FADE_EN
      for (int c = 0; c < 3; c++) begin
        if (32'(cnt_nxt) >= CH_W) rgb_nxt[c*CH_W +: CH_W] = '0;
        else rgb_nxt[c*CH_W +: CH_W] = rgb_sel[c*CH_W +: CH_W] >> cnt_nxt;
      end
`else
      rgb_nxt = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SHOW;
      cur       <= SEL_W'(RST_SRC);
      pend      <= SEL_W'(RST_SRC);
      blank_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      blank_cnt <= cnt_nxt;
      if (sel_ok) pend <= sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_hcount <= '0;
      out_vcount <= '0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_hblnk  <= 1'b0;
      out_vblnk  <= 1'b0;
      out_rgb    <= '0;
      switching  <= 1'b0;
    end else begin
      out_hcount <= src_hcount[CNT_W*int'(cur_nxt) +: CNT_W];
      out_vcount <= src_vcount[CNT_W*int'(cur_nxt) +: CNT_W];
      out_hsync  <= src_hsync[cur_nxt];
      out_vsync  <= src_vsync[cur_nxt];
      out_hblnk  <= src_hblnk[cur_nxt];
      out_vblnk  <= src_vblnk[cur_nxt];
      out_rgb    <= rgb_nxt;
      switching  <= (state_nxt != SHOW);
    end
  end

  assign cur_src = cur;

endmodule
